// File: rtl/logic_op_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_issuer_pkg
// Description : Shared opcode and FSM state encodings for the logic-op issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_op_issuer_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    // Opcodes map directly onto unit_L's {S1,S0} select lines.
    localparam op_t OP_ILLEGAL = 2'b00;
    localparam op_t OP_AND     = 2'b01;
    localparam op_t OP_OR      = 2'b10;
    localparam op_t OP_XOR     = 2'b11;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage : logic_op_issuer_pkg
`default_nettype wire

// File: rtl/unit_L.sv
`default_nettype none
// ============================================================================
// Module      : unit_L
// Description : Combinational logic unit; {s1,s0} selects AND / OR / XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_L #(
    parameter int WIDTH = 32
) (
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case ({s1, s0})
            2'b01:   y = a & b;
            2'b10:   y = a | b;
            2'b11:   y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule : unit_L
`default_nettype wire

// File: rtl/logic_op_issuer.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_issuer
// Description : Valid/ready front end for unit_L with operand capture,
//               illegal-op masking and a saturating completed-op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_issuer
    import logic_op_issuer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lu_out;

    unit_L #(
        .WIDTH (WIDTH)
    ) u_unit_L (
        .s1 (op_q[1]),
        .s0 (op_q[0]),
        .a  (a_q),
        .b  (b_q),
        .y  (lu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ILLEGAL;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are frozen after acceptance so unit_L never sees live inputs.
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (state_q == ST_IDLE && req_valid) begin
            op_d = req_op;
            a_d  = req_a;
            b_d  = req_b;
        end
        if (state_q == ST_EXEC) begin
            err_d  = (op_q == OP_ILLEGAL);
            data_d = (op_q == OP_ILLEGAL) ? '0 : lu_out;
        end
        if (state_q == ST_RESP && rsp_ready && !err_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) && !rst;
        rsp_valid = (state_q == ST_RESP);
        rsp_data  = data_q;
        rsp_err   = err_q;
        op_count  = cnt_q;
    end

endmodule : logic_op_issuer
`default_nettype wire

// File: tb/tb_logic_op_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_op_issuer
// Description : Directed self-checking bench for logic_op_issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_op_issuer;

    localparam logic [31:0] C_A = 32'hDC754CD2;
    localparam logic [31:0] C_B = 32'h4124F055;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [15:0] op_count;

    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_data;
    logic [1:0]  s_op_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_op_issuer #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
    );

    logic_op_issuer #(.WIDTH(32), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .op_count(s_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // response handshake (rsp_ready is held high).
    task automatic txn(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_data,
                       input logic exp_err);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = 32'h1234_5678;
        req_b     = 32'h8765_4321;
        chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_exec_ready"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_resp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // 1: AND
        txn("and", 2'b01, C_A, C_B, 32'h40244050, 1'b0);
        chk("and_count", {16'd0, op_count}, 32'd1);
        chk("and_ready", {31'd0, req_ready}, 32'd1);

        // 2: OR then XOR back-to-back, counting from a fresh reset
        do_reset();
        txn("or", 2'b10, C_A, C_B, 32'hDD75FCD7, 1'b0);
        txn("xor", 2'b11, C_A, C_B, 32'h9D51BC87, 1'b0);
        chk("b2b_count", {16'd0, op_count}, 32'd2);

        // 3: back-pressure with a stray request pulse during the stall
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = C_A;
        req_b     = C_B;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            req_op    = 2'b01;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_data, 32'h9D51BC87);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_count", {16'd0, op_count}, 32'd3);
        @(negedge clk);
        chk("bp_no_stray_accept", {31'd0, req_ready}, 32'd1);

        // 4: illegal op
        txn("illegal", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
        chk("illegal_count", {16'd0, op_count}, 32'd3);

        // 5: reset while a response is pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = C_A;
        req_b     = C_B;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_resp_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, op_count}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        txn("post_rst_and", 2'b01, C_A, C_B, 32'h40244050, 1'b0);
        chk("post_rst_count", {16'd0, op_count}, 32'd1);

        // 6: saturation on the CNT_W=2 instance (five legal ops since reset)
        txn("sat2", 2'b10, C_A, C_B, 32'hDD75FCD7, 1'b0);
        txn("sat3", 2'b11, C_A, C_B, 32'h9D51BC87, 1'b0);
        chk("sat_at3", {30'd0, s_op_count}, 32'd3);
        txn("sat4", 2'b01, C_A, C_B, 32'h40244050, 1'b0);
        txn("sat5", 2'b10, C_A, C_B, 32'hDD75FCD7, 1'b0);
        chk("sat_stuck", {30'd0, s_op_count}, 32'd3);
        chk("sat_data", s_rsp_data, 32'hDD75FCD7);
        chk("wide_count", {16'd0, op_count}, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_logic_op_issuer
`default_nettype wire
